coherence_bus_control: RTL and testbench



---
 rtl/coherence_bus_control.sv | 218 +++++++++++++++++++++
 tb/tb_coherence_bus_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_control.sv
// coherence_bus_control
//   Memory-side responder for two dcache/icache pairs. Arbitrates instruction
//   and data requests onto one RAM port and runs MSI snooping (snoop
//   broadcast, invalidation, cache-to-cache transfer with RAM update).
//
// Ports
//   CLK, nRST                 clock, async active-low reset
//   iREN/iaddr -> iwait/iload icache read channel, one per cache
//   dREN/dWEN/daddr/dstore    dcache request channel
//     -> dwait/dload
//   cctrans/ccwrite           coherence request (requester) or ack (snooper)
//   ccwait/ccinv/ccsnoopaddr  snoop strobe, invalidate, address to the snooper
//   ramREN/ramWEN/ramaddr/    RAM port. A word completes only in a cycle where
//   ramstore/ramload/ramstate ramstate == ACCESS.
//
// Optional build macro
//   COHERENCE_STATS_EN adds snoop_count / c2c_count / inval_count outputs,
//   which count entries into SNOOP, C2C and INVAL.
//
// CPUS is fixed at 2: the owner / other-cache pair is a single bit.

module coherence_bus_control_lane (
  input  logic iren_i,
  input  logic dren_i,
  input  logic dwen_i,
  input  logic cctrans_i,
  input  logic ccwrite_i,
  output logic dreq_o,
  output logic ireq_o
);
  // An upgrade (cctrans + ccwrite with no data op) competes in the data class.
  assign dreq_o = dren_i | dwen_i | (cctrans_i & ccwrite_i);
  assign ireq_o = iren_i;
endmodule

module coherence_bus_control #(
  parameter int CPUS       = 2,
  parameter int RAM_ADDR_W = 32
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [CPUS-1:0]                  iREN,
  input  logic [CPUS-1:0][RAM_ADDR_W-1:0]  iaddr,
  output logic [CPUS-1:0]                  iwait,
  output logic [CPUS-1:0][31:0]            iload,
  input  logic [CPUS-1:0]                  dREN,
  input  logic [CPUS-1:0]                  dWEN,
  input  logic [CPUS-1:0][RAM_ADDR_W-1:0]  daddr,
  input  logic [CPUS-1:0][31:0]            dstore,
  output logic [CPUS-1:0]                  dwait,
  output logic [CPUS-1:0][31:0]            dload,
  input  logic [CPUS-1:0]                  cctrans,
  input  logic [CPUS-1:0]                  ccwrite,
  output logic [CPUS-1:0]                  ccwait,
  output logic [CPUS-1:0]                  ccinv,
  output logic [CPUS-1:0][RAM_ADDR_W-1:0]  ccsnoopaddr,
  output logic                             ramREN,
  output logic                             ramWEN,
  output logic [RAM_ADDR_W-1:0]            ramaddr,
  output logic [31:0]                      ramstore,
  input  logic [31:0]                      ramload,
  input  logic [1:0]                       ramstate
`ifdef COHERENCE_STATS_EN
  ,
  output logic [31:0]                      snoop_count,
  output logic [31:0]                      c2c_count,
  output logic [31:0]                      inval_count
`endif
);

  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    IDLE, IFETCH, WRITE, LOAD, SNOOP, C2C, INVAL
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_ptr_q, rr_ptr_d;
  logic   pick;
  logic   r, o, acc;

  logic [CPUS-1:0] dreq, ireq;

  for (genvar g = 0; g < CPUS; g++) begin : g_lane
    coherence_bus_control_lane u_lane (
      .iren_i    (iREN[g]),
      .dren_i    (dREN[g]),
      .dwen_i    (dWEN[g]),
      .cctrans_i (cctrans[g]),
      .ccwrite_i (ccwrite[g]),
      .dreq_o    (dreq[g]),
      .ireq_o    (ireq[g])
    );
  end

  assign r   = owner_q;
  assign o   = ~owner_q;
  assign acc = (ramstate == RS_ACCESS);

  // Handshake outputs are decoded from the registered state so that the
  // served wait bit can fall in the very cycle the RAM reports ACCESS.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    pick        = rr_ptr_q;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        // Data class beats instruction class; rr_ptr breaks ties within a class.
        if (|dreq) pick = dreq[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        else       pick = ireq[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        if (|dreq || |ireq) owner_d = pick;
        if      (dWEN[pick])                     state_d = WRITE;
        else if (dREN[pick] && cctrans[pick])    state_d = SNOOP;
        else if (dREN[pick])                     state_d = LOAD;
        else if (cctrans[pick] && ccwrite[pick]) state_d = INVAL;
        else if (iREN[pick])                     state_d = IFETCH;
      end
      IFETCH: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr[r];
        iload[r] = ramload;
        iwait[r] = ~acc;
        if (acc) state_d = IDLE;
      end
      WRITE: begin
        // Strobe follows the request so a dropped request never hits RAM.
        ramWEN   = dWEN[r];
        ramaddr  = daddr[r];
        ramstore = dstore[r];
        dwait[r] = ~acc;
        if (!dWEN[r]) state_d = IDLE;
      end
      LOAD: begin
        ramREN   = dREN[r];
        ramaddr  = daddr[r];
        dload[r] = ramload;
        dwait[r] = ~acc;
        if (!dREN[r]) state_d = IDLE;
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[r];
        ccinv[o]       = ccwrite[r];
        if (!dREN[r])        state_d = IDLE;
        else if (cctrans[o]) state_d = ccwrite[o] ? C2C : LOAD;
      end
      C2C: begin
        // Snooper's dirty write goes to RAM and is forwarded to the requester.
        ccwait[o]      = 1'b1;
        ccsnoopaddr[o] = daddr[r];
        ramWEN         = dWEN[o];
        ramaddr        = daddr[o];
        ramstore       = dstore[o];
        dload[r]       = dstore[o];
        dwait[o]       = ~acc;
        dwait[r]       = ~acc;
        if (!dWEN[o]) state_d = IDLE;
      end
      INVAL: begin
        ccwait[o]      = 1'b1;
        ccinv[o]       = 1'b1;
        ccsnoopaddr[o] = daddr[r];
        dwait[r]       = ~cctrans[o];
        if (cctrans[o]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_d == IDLE) rr_ptr_d = ~rr_ptr_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef COHERENCE_STATS_EN
  logic [31:0] snoop_cnt_q, c2c_cnt_q, inval_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_cnt_q <= '0;
      c2c_cnt_q   <= '0;
      inval_cnt_q <= '0;
    end else begin
      if (state_q != SNOOP && state_d == SNOOP) snoop_cnt_q <= snoop_cnt_q + 32'd1;
      if (state_q != C2C   && state_d == C2C)   c2c_cnt_q   <= c2c_cnt_q + 32'd1;
      if (state_q != INVAL && state_d == INVAL) inval_cnt_q <= inval_cnt_q + 32'd1;
    end
  end

  assign snoop_count = snoop_cnt_q;
  assign c2c_count   = c2c_cnt_q;
  assign inval_count = inval_cnt_q;
`endif

endmodule

// File: tb/tb_coherence_bus_control.sv
// Directed bench for coherence_bus_control: behavioural RAM with a settable
// BUSY latency, per-cache requester/snooper models, and scoreboard queues of
// expected RAM operations and cache completions.

module tb_coherence_bus_control;
  logic CLK = 1'b0;
  logic nRST;
  logic [1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv, ramstate;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;

  coherence_bus_control dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;
  int ram_lat = 0, busy = 0, n_ren = 0, n_wen = 0;
  int n_ilow [2], n_dlow [2], dwords [2], snp_seen [2];
  logic sresp [2], sdirty [2], snp_inv [2];
  logic [31:0] snp_addr [2];
  logic c2c_mode = 1'b0;
  logic [64:0] exp_ram [$];   // {we, addr, wdata}
  logic [33:0] exp_d [$];     // {cache, check_data, dload}
  logic [32:0] exp_i [$];     // {cache, iload}
  logic [31:0] sdq [$];       // data a dirty snooper writes back

  function automatic logic [31:0] ramdat(input logic [31:0] a);
    return (a == 32'h40) ? 32'h1234 : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [64:0] er;
    logic [33:0] ed;
    logic [32:0] ei;
    @(posedge CLK); #1;
    // RAM: ram_lat BUSY cycles, then one ACCESS per word
    if (ramREN || ramWEN) begin
      if (busy < ram_lat) begin ramstate = 2'd1; busy++; end
      else begin ramstate = 2'd2; busy = 0; ramload = ramdat(ramaddr); end
    end else begin
      ramstate = 2'd0; busy = 0;
    end
    if (ramREN) n_ren++;
    if (ramWEN) n_wen++;
    // snooper reaction
    for (int c = 0; c < 2; c++) begin
      if (sresp[c] && ccwait[c] && !cctrans[c]) begin
        cctrans[c] = 1'b1; ccwrite[c] = sdirty[c];
        snp_addr[c] = ccsnoopaddr[c]; snp_inv[c] = ccinv[c]; snp_seen[c]++;
        if (sdirty[c]) begin
          dWEN[c] = 1'b1; daddr[c] = ccsnoopaddr[c]; dstore[c] = sdq.pop_front(); dwords[c] = 2;
        end
      end else if (sresp[c] && !ccwait[c] && cctrans[c]) begin
        cctrans[c] = 1'b0; ccwrite[c] = 1'b0; sresp[c] = 1'b0;
      end
    end
    #1;
    if (ramstate == 2'd2 && (ramREN || ramWEN)) begin
      chk("ram_op_expected", exp_ram.size() != 0, 1);
      if (exp_ram.size() != 0) begin
        er = exp_ram.pop_front();
        chk("ram_op", {ramWEN, ramaddr, ramWEN ? ramstore : 32'h0}, er);
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (!iwait[c]) begin
        n_ilow[c]++;
        chk("icomp_expected", exp_i.size() != 0, 1);
        if (exp_i.size() != 0) begin
          ei = exp_i.pop_front();
          chk("iload", {c[0], iload[c]}, ei);
        end
        iREN[c] = 1'b0;
      end
    end
    if (c2c_mode && dwait != 2'b11) chk("c2c_dwait_pair", dwait, 2'b00);
    for (int c = 0; c < 2; c++) begin
      if (!dwait[c]) begin
        n_dlow[c]++;
        chk("dcomp_expected", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) begin
          ed = exp_d.pop_front();
          chk("dcomp_cache", c, ed[33]);
          if (ed[32]) chk("dload", dload[c], ed[31:0]);
        end
        dwords[c]--;
        daddr[c] += 32'd4;
        if (dwords[c] <= 0) begin
          dREN[c] = 1'b0; dWEN[c] = 1'b0;
          if (!sresp[c]) begin cctrans[c] = 1'b0; ccwrite[c] = 1'b0; end
        end else if (sresp[c] && sdq.size() != 0) begin
          dstore[c] = sdq.pop_front();
        end
      end
    end
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, exp_ram.size() + exp_d.size() + exp_i.size(), 0);
  endtask

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = '0;
    for (int c = 0; c < 2; c++) begin
      n_ilow[c] = 0; n_dlow[c] = 0; dwords[c] = 0; snp_seen[c] = 0;
      sresp[c] = 1'b0; sdirty[c] = 1'b0; snp_inv[c] = 1'b0; snp_addr[c] = '0;
    end
    #12;
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ram_strobes", {ramREN, ramWEN}, 2'b00);
    chk("rst_cc", {ccwait, ccinv}, 4'b0000);
    chk("rst_ram_bus", {ramaddr, ramstore}, 64'h0);
    chk("rst_loads", {iload, dload, ccsnoopaddr}, 96'h0);
    @(negedge CLK); nRST = 1'b1;

    // fetch, 2 BUSY cycles before ACCESS
    ram_lat = 2; n_ren = 0;
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    exp_i.push_back({1'b0, 32'h1234});
    exp_ram.push_back({1'b0, 32'h40, 32'h0});
    repeat (8) cyc();
    chk("fetch_ren_cycles", n_ren, 3);
    chk("fetch_iwait_low_cycles", n_ilow[0], 1);
    chk_empty("fetch_drained");

    // lone fetch by cache1 (leaves rr_ptr at 0 for the alternation below)
    ram_lat = 0;
    iREN[1] = 1'b1; iaddr[1] = 32'h48;
    exp_i.push_back({1'b1, ramdat(32'h48)});
    exp_ram.push_back({1'b0, 32'h48, 32'h0});
    repeat (4) cyc();

    // data from cache1 beats instruction from cache0
    dREN[1] = 1'b1; daddr[1] = 32'h200; dwords[1] = 1;
    iREN[0] = 1'b1; iaddr[0] = 32'h300;
    exp_ram.push_back({1'b0, 32'h200, 32'h0});
    exp_ram.push_back({1'b0, 32'h300, 32'h0});
    exp_d.push_back({1'b1, 1'b1, ramdat(32'h200)});
    exp_i.push_back({1'b0, ramdat(32'h300)});
    repeat (8) cyc();
    chk_empty("arb_prio_drained");

    // both dREN twice: order 0,1,0,1
    daddr[0] = 32'h400; daddr[1] = 32'h500;
    dREN = 2'b11; dwords[0] = 1; dwords[1] = 1;
    exp_ram.push_back({1'b0, 32'h400, 32'h0});
    exp_ram.push_back({1'b0, 32'h500, 32'h0});
    exp_ram.push_back({1'b0, 32'h404, 32'h0});
    exp_ram.push_back({1'b0, 32'h504, 32'h0});
    exp_d.push_back({1'b0, 1'b1, ramdat(32'h400)});
    exp_d.push_back({1'b1, 1'b1, ramdat(32'h500)});
    exp_d.push_back({1'b0, 1'b1, ramdat(32'h404)});
    exp_d.push_back({1'b1, 1'b1, ramdat(32'h504)});
    repeat (8) cyc();
    dREN = 2'b11; dwords[0] = 1; dwords[1] = 1;
    repeat (8) cyc();
    chk_empty("arb_rr_drained");

    // clean-miss snoop
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b0; daddr[0] = 32'h80; dwords[0] = 2;
    sresp[1] = 1'b1; sdirty[1] = 1'b0; snp_inv[1] = 1'b1;
    exp_ram.push_back({1'b0, 32'h80, 32'h0});
    exp_ram.push_back({1'b0, 32'h84, 32'h0});
    exp_d.push_back({1'b0, 1'b1, ramdat(32'h80)});
    exp_d.push_back({1'b0, 1'b1, ramdat(32'h84)});
    repeat (10) cyc();
    chk("clean_snoop_seen", snp_seen[1], 1);
    chk("clean_snoopaddr", snp_addr[1], 32'h80);
    chk("clean_ccinv", snp_inv[1], 1'b0);
    chk_empty("clean_drained");

    // dirty snoop: cache-to-cache with RAM write-back
    ram_lat = 1; c2c_mode = 1'b1; n_dlow[0] = 0; n_dlow[1] = 0;
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h100; dwords[0] = 2;
    sresp[1] = 1'b1; sdirty[1] = 1'b1;
    sdq.push_back(32'hAA); sdq.push_back(32'hBB);
    exp_ram.push_back({1'b1, 32'h100, 32'hAA});
    exp_ram.push_back({1'b1, 32'h104, 32'hBB});
    exp_d.push_back({1'b0, 1'b1, 32'hAA});
    exp_d.push_back({1'b1, 1'b0, 32'h0});
    exp_d.push_back({1'b0, 1'b1, 32'hBB});
    exp_d.push_back({1'b1, 1'b0, 32'h0});
    repeat (12) cyc();
    c2c_mode = 1'b0;
    chk("dirty_ccinv", snp_inv[1], 1'b1);
    chk("dirty_snoopaddr", snp_addr[1], 32'h100);
    chk("dirty_words", {n_dlow[0], n_dlow[1]}, {32'd2, 32'd2});
    chk_empty("dirty_drained");

    // upgrade: invalidate only, no RAM traffic
    n_ren = 0; n_wen = 0; n_dlow[1] = 0; snp_inv[0] = 1'b0;
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dwords[1] = 1;
    sresp[0] = 1'b1; sdirty[0] = 1'b0;
    exp_d.push_back({1'b1, 1'b0, 32'h0});
    repeat (6) cyc();
    chk("upg_ccinv", snp_inv[0], 1'b1);
    chk("upg_dwait_low_cycles", n_dlow[1], 1);
    chk("upg_no_ram", n_ren + n_wen, 0);
    chk_empty("upg_drained");

    // reset in the middle of C2C
    ram_lat = 3;
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h180; dwords[0] = 2;
    sresp[1] = 1'b1; sdirty[1] = 1'b1;
    sdq.push_back(32'hCC); sdq.push_back(32'hDD);
    for (int k = 0; k < 10 && !ramWEN; k++) cyc();
    chk("c2c_reached", ramWEN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_ramWEN", ramWEN, 1'b0);
    chk("midrst_ccwait", ccwait, 2'b00);
    chk("midrst_waits", {iwait, dwait}, 4'b1111);
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramstate = '0; busy = 0;
    for (int c = 0; c < 2; c++) begin sresp[c] = 1'b0; sdirty[c] = 1'b0; dwords[c] = 0; end
    sdq.delete(); exp_ram.delete(); exp_d.delete(); exp_i.delete();
    @(negedge CLK); nRST = 1'b1;
    ram_lat = 0;
    iREN[1] = 1'b1; iaddr[1] = 32'h40;
    exp_i.push_back({1'b1, 32'h1234});
    exp_ram.push_back({1'b0, 32'h40, 32'h0});
    repeat (4) cyc();
    chk_empty("post_rst_fetch_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
